// File: rtl/imm_rotate_encoder_pkg.sv
// Shared types, widths and rotation helper for the operand-2 immediate encoder.
package imm_rotate_encoder_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ROT_STEPS = 16;
    localparam int unsigned ROT_W     = 4;
    localparam int unsigned IMM8_W    = 8;
    localparam int unsigned SHOP_W    = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Rotate left by amt (0..31); amt of 0 returns x unchanged.
    function automatic logic [DATA_W-1:0] rol32(input logic [DATA_W-1:0] x,
                                                input logic [4:0]        amt);
        logic [2*DATA_W-1:0] dbl;
        dbl = {x, x} << amt;
        return dbl[2*DATA_W-1:DATA_W];
    endfunction

endpackage

// File: rtl/imm_rotate_encoder_fit_check.sv
// Tests whether a 32-bit value, rotated left by 2*rot, fits in the low 8 bits.
module imm_fit_check
    import imm_rotate_encoder_pkg::*;
(
    input  logic [DATA_W-1:0] value_i,
    input  logic [ROT_W-1:0]  rot_i,
    output logic              fit_c,
    output logic [IMM8_W-1:0] imm8_c
);

    logic [DATA_W-1:0] rotated;

    // Undo the decode rotation and see whether only the imm8 field is populated.
    always_comb begin
        rotated = rol32(value_i, {rot_i, 1'b0});
        fit_c   = (rotated[DATA_W-1:IMM8_W] == '0);
        imm8_c  = rotated[IMM8_W-1:0];
    end

endmodule

// File: rtl/imm_rotate_encoder.sv
// Multi-cycle search for the {rotate_imm, imm8} encoding of a 32-bit constant.
module imm_rotate_encoder
    import imm_rotate_encoder_pkg::*;
#(
    parameter bit ALLOW_INVERT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              done,
    output logic              encodable,
    output logic              inverted,
    output logic [SHOP_W-1:0] shift_operand
);

    state_e            state_q, state_d;
    logic [ROT_W-1:0]  rot_q, rot_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              enc_q, enc_d;
    logic              inv_q, inv_d;
    logic [SHOP_W-1:0] shop_q, shop_d;

    logic              plain_fit_c, inv_raw_fit_c, inv_fit_c;
    logic [IMM8_W-1:0] plain_imm8_c, inv_imm8_c;

    imm_fit_check u_plain_fit (
        .value_i (val_q),
        .rot_i   (rot_q),
        .fit_c   (plain_fit_c),
        .imm8_c  (plain_imm8_c)
    );

    imm_fit_check u_inv_fit (
        .value_i (~val_q),
        .rot_i   (rot_q),
        .fit_c   (inv_raw_fit_c),
        .imm8_c  (inv_imm8_c)
    );

    assign inv_fit_c = ALLOW_INVERT && inv_raw_fit_c;

    // Next-state and result computation; smallest rotation wins, plain before inverted.
    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        val_d   = val_q;
        enc_d   = enc_q;
        inv_d   = inv_q;
        shop_d  = shop_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    val_d   = value;
                    rot_d   = '0;
                    enc_d   = 1'b0;
                    inv_d   = 1'b0;
                    shop_d  = '0;
                    state_d = ST_SEARCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (plain_fit_c) begin
                    enc_d   = 1'b1;
                    inv_d   = 1'b0;
                    shop_d  = {rot_q, plain_imm8_c};
                    state_d = ST_DONE;
                end else if (inv_fit_c) begin
                    enc_d   = 1'b1;
                    inv_d   = 1'b1;
                    shop_d  = {rot_q, inv_imm8_c};
                    state_d = ST_DONE;
                end else if (rot_q == ROT_W'(ROT_STEPS - 1)) begin
                    enc_d   = 1'b0;
                    inv_d   = 1'b0;
                    shop_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    rot_d   = rot_q + ROT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SEARCH);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rot_q   <= '0;
            val_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            enc_q   <= 1'b0;
            inv_q   <= 1'b0;
            shop_q  <= '0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            enc_q   <= enc_d;
            inv_q   <= inv_d;
            shop_q  <= shop_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign encodable     = enc_q;
    assign inverted      = inv_q;
    assign shift_operand = shop_q;

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Directed scoreboard bench for imm_rotate_encoder (inverting and non-inverting builds).
module tb_imm_rotate_encoder;

    typedef struct {
        int unsigned cyc;
        logic        enc;
        logic        inv;
        logic [11:0] sh;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [31:0] value;

    logic        busy_a, done_a, enc_a, inv_a;
    logic [11:0] sh_a;
    logic        busy_b, done_b, enc_b, inv_b;
    logic [11:0] sh_b;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];

    imm_rotate_encoder dut (
        .clk(clk), .rst(rst), .start(start_a), .value(value),
        .busy(busy_a), .done(done_a), .encodable(enc_a), .inverted(inv_a),
        .shift_operand(sh_a)
    );

    imm_rotate_encoder #(.ALLOW_INVERT(1'b0)) dut_ni (
        .clk(clk), .rst(rst), .start(start_b), .value(value),
        .busy(busy_b), .done(done_b), .encodable(enc_b), .inverted(inv_b),
        .shift_operand(sh_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the inverting build: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_done_cycle", cyc, e.cyc);
                check("a_encodable", 32'(enc_a), 32'(e.enc));
                check("a_inverted", 32'(inv_a), 32'(e.inv));
                check("a_shift_operand", 32'(sh_a), 32'(e.sh));
            end
        end
    end

    // Scoreboard for the non-inverting build.
    always @(negedge clk) begin
        if (done_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_done_cycle", cyc, e.cyc);
                check("b_encodable", 32'(enc_b), 32'(e.enc));
                check("b_inverted", 32'(inv_b), 32'(e.inv));
                check("b_shift_operand", 32'(sh_b), 32'(e.sh));
            end
        end
    end

    task automatic launch_a(input logic [31:0] v, input logic e, input logic i,
                            input logic [11:0] s, input int unsigned lat);
        exp_t x;
        @(negedge clk);
        start_a = 1'b1;
        value   = v;
        x.cyc = cyc + lat; x.enc = e; x.inv = i; x.sh = s;
        q_a.push_back(x);
        @(negedge clk);
        start_a = 1'b0;
        value   = $urandom;
    endtask

    task automatic launch_b(input logic [31:0] v, input logic e, input logic i,
                            input logic [11:0] s, input int unsigned lat);
        exp_t x;
        @(negedge clk);
        start_b = 1'b1;
        value   = v;
        x.cyc = cyc + lat; x.enc = e; x.inv = i; x.sh = s;
        q_b.push_back(x);
        @(negedge clk);
        start_b = 1'b0;
        value   = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q_a.size() != 0 || q_b.size() != 0) begin
            check("drain_timeout", 32'(q_a.size() + q_b.size()), 32'd0);
            q_a.delete();
            q_b.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; value = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_enc", 32'(enc_a), 32'd0);
        check("rst_inv", 32'(inv_a), 32'd0);
        check("rst_shop", 32'(sh_a), 32'd0);
        rst = 1'b0;

        // 0xFF: hit at r=0; busy only in cycle 1
        launch_a(32'h0000_00FF, 1'b1, 1'b0, 12'h0FF, 2);
        check("busy_cycle1", 32'(busy_a), 32'd1);
        @(negedge clk);
        check("busy_cycle2", 32'(busy_a), 32'd0);
        drain();

        launch_a(32'h0003_FC00, 1'b1, 1'b0, 12'hBFF, 13);
        drain();
        launch_a(32'hF000_000F, 1'b1, 1'b0, 12'h2FF, 4);
        drain();
        // held result after a hit
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_hit_done", 32'(done_a), 32'd0);
            check("hold_hit_shop", 32'(sh_a), 32'h2FF);
            check("hold_hit_enc", 32'(enc_a), 32'd1);
        end

        // inverted form vs non-inverting build
        launch_a(32'hFFFF_FF00, 1'b1, 1'b1, 12'h0FF, 2);
        drain();
        launch_b(32'hFFFF_FF00, 1'b0, 1'b0, 12'h000, 17);
        drain();
        launch_a(32'hFFFF_FFFF, 1'b1, 1'b1, 12'h000, 2);
        drain();
        launch_b(32'hFFFF_FFFF, 1'b0, 1'b0, 12'h000, 17);
        drain();
        launch_a(32'h0000_0000, 1'b1, 1'b0, 12'h000, 2);
        drain();

        // 9-bit span: not encodable, result held
        launch_a(32'h0000_0101, 1'b0, 1'b0, 12'h000, 17);
        drain();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_miss_done", 32'(done_a), 32'd0);
            check("hold_miss_enc", 32'(enc_a), 32'd0);
            check("hold_miss_shop", 32'(sh_a), 32'd0);
        end

        // back-to-back: restart during DONE
        begin
            exp_t x;
            @(negedge clk);
            start_a = 1'b1; value = 32'h0000_00FF;
            x.cyc = cyc + 2; x.enc = 1'b1; x.inv = 1'b0; x.sh = 12'h0FF;
            q_a.push_back(x);
            @(negedge clk);
            start_a = 1'b0;
            @(negedge clk);
            check("b2b_in_done", 32'(done_a), 32'd1);
            start_a = 1'b1; value = 32'h0000_0000;
            x.cyc = cyc + 2; x.enc = 1'b1; x.inv = 1'b0; x.sh = 12'h000;
            q_a.push_back(x);
            @(negedge clk);
            start_a = 1'b0;
        end
        drain();

        // starts during SEARCH are ignored
        launch_a(32'h0003_FC00, 1'b1, 1'b0, 12'hBFF, 13);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start_a = 1'b1; value = 32'h0000_00FF;
            @(negedge clk);
            start_a = 1'b0;
        end
        drain();

        // reset mid-search: no done, outputs cleared
        @(negedge clk);
        start_a = 1'b1; value = 32'h0000_0101;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_done", 32'(done_a), 32'd0);
        check("midrst_enc", 32'(enc_a), 32'd0);
        check("midrst_inv", 32'(inv_a), 32'd0);
        check("midrst_shop", 32'(sh_a), 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done_a), 32'd0);
        end
        launch_a(32'h0000_00FF, 1'b1, 1'b0, 12'h0FF, 2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

endmodule
